// File: rtl/shift_add_mult_ctrl_if.sv
// Handshake and command bundle between the shift-and-add multiplier controller,
// its host and its datapath.
//   start, abort   : host -> controller commands
//   mplr_bit       : datapath -> controller, current multiplier LSB
//   load_ops       : load multiplicand/multiplier registers
//   init_acc       : clear the accumulator
//   load_acc       : acc <= acc + multiplicand
//   shift_en       : shift the accumulator/multiplier pair right by one
//   busy, done     : status back to the host
//   iter_count     : completed shift iterations
// master = host/datapath side, slave = controller side.
interface shift_add_mult_ctrl_if #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned CNT_W     = $clog2(BIT_WIDTH + 1)
);
    logic             start;
    logic             abort;
    logic             mplr_bit;
    logic             load_ops;
    logic             init_acc;
    logic             load_acc;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] iter_count;

    modport master (
        output start, abort, mplr_bit,
        input  load_ops, init_acc, load_acc, shift_en, busy, done, iter_count
    );

    modport slave (
        input  start, abort, mplr_bit,
        output load_ops, init_acc, load_acc, shift_en, busy, done, iter_count
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for a sequential shift-and-add multiplier.
// Sequence: IDLE -> LOAD -> (ADD -> SHIFT) x BIT_WIDTH -> DONE -> IDLE.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : shift_add_mult_ctrl_if.slave (start/abort/mplr_bit in; datapath
//           commands, busy/done status and iter_count out)
// All outputs except load_acc are registered decodes of the state; load_acc
// additionally gates the registered ADD flag with the live multiplier LSB.
module shift_add_mult_ctrl #(
    parameter  int unsigned BIT_WIDTH = 16,
    localparam int unsigned CNT_W     = $clog2(BIT_WIDTH + 1)
) (
    input logic                   clk,
    input logic                   rst_n,
    shift_add_mult_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StAdd   = 3'd2,
        StShift = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             load_ops_q, init_acc_q, add_q, shift_en_q, busy_q, done_q;
    logic             last_shift;

    assign last_shift = (iter_q == CNT_W'(BIT_WIDTH - 1));

    always_comb begin
        state_d = StIdle;
        iter_d  = iter_q;
        case (state_q)
            StIdle:  state_d = bus.start ? StLoad : StIdle;
            StLoad: begin
                state_d = StAdd;
                iter_d  = '0;
            end
            StAdd:   state_d = StShift;
            StShift: begin
                iter_d  = iter_q + CNT_W'(1);
                state_d = last_shift ? StDone : StAdd;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;  // unused encodings recover to IDLE
        endcase
        // Abort wins over everything; the count is frozen where it stood.
        if (bus.abort) begin
            state_d = StIdle;
            iter_d  = iter_q;
        end
    end

    // Output flags are registered from the next state so they always match
    // the decode of state_q in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            iter_q     <= '0;
            load_ops_q <= 1'b0;
            init_acc_q <= 1'b0;
            add_q      <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            load_ops_q <= (state_d == StLoad);
            init_acc_q <= (state_d == StLoad);
            add_q      <= (state_d == StAdd);
            shift_en_q <= (state_d == StShift);
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
        end
    end

    assign bus.load_ops   = load_ops_q;
    assign bus.init_acc   = init_acc_q;
    assign bus.load_acc   = add_q & bus.mplr_bit;
    assign bus.shift_en   = shift_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: a BIT_WIDTH=16 instance wrapped in a
// behavioural datapath with a product/latency scoreboard, plus a BIT_WIDTH=2
// instance checked cycle by cycle against a fixed output trace.
module tb_shift_add_mult_ctrl;

    localparam int unsigned BW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    shift_add_mult_ctrl_if #(.BIT_WIDTH(BW)) bus ();
    shift_add_mult_ctrl #(.BIT_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    shift_add_mult_ctrl_if #(.BIT_WIDTH(2)) bus2 ();
    shift_add_mult_ctrl #(.BIT_WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Behavioural datapath: 17-bit accumulator (with carry) and multiplier reg.
    logic [15:0] a_op = '0, b_op = '0;
    logic [15:0] dp_mcand = '0, dp_mplr = '0;
    logic [16:0] dp_acc = '0;

    always @(posedge clk) begin
        if (bus.load_ops) begin
            dp_mcand <= a_op;
            dp_mplr  <= b_op;
        end
        if (bus.init_acc) begin
            dp_acc <= '0;
        end else if (bus.load_acc) begin
            dp_acc <= dp_acc + {1'b0, dp_mcand};
        end else if (bus.shift_en) begin
            dp_acc  <= {1'b0, dp_acc[16:1]};
            dp_mplr <= {dp_acc[0], dp_mplr[15:1]};
        end
    end

    assign bus.mplr_bit  = dp_mplr[0];
    assign bus2.mplr_bit = 1'b1;

    typedef struct {
        logic [31:0] prod;
        int          done_edge;
        int          adds;
    } exp_t;

    exp_t sb[$];

    // Monitor: per-operation pulse counts, compared against the scoreboard on done.
    int   shifts = 0, adds = 0, loads = 0;
    logic prev_load = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_load) check("iter_clear_after_load", 64'(bus.iter_count), 64'd0);
            if (bus.load_ops) begin
                check("init_with_load", 64'(bus.init_acc), 64'd1);
                if (prev_load) begin
                    loads++;
                end else begin
                    loads  = 1;
                    shifts = 0;
                    adds   = 0;
                end
            end
            if (bus.shift_en) shifts++;
            if (bus.load_acc) adds++;
            if (bus.done) begin
                check("pending_at_done", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_edge", 64'(edge_cnt), 64'(e.done_edge));
                    check("product", 64'({dp_acc[15:0], dp_mplr}), 64'(e.prod));
                    check("busy_at_done", 64'(bus.busy), 64'd1);
                    check("iter_at_done", 64'(bus.iter_count), 64'(BW));
                    check("shift_pulses", 64'(shifts), 64'(BW));
                    check("add_pulses", 64'(adds), 64'(e.adds));
                    check("load_cycles", 64'(loads), 64'd1);
                end
            end
            prev_load = bus.load_ops;
        end else begin
            prev_load = 1'b0;
        end
    end

    // Start is sampled at edge_cnt+1, done follows 2*BW+1 edges later.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        @(negedge clk);
        a_op      = a;
        b_op      = b;
        bus.start = 1'b1;
        e.prod      = {16'd0, a} * {16'd0, b};
        e.done_edge = edge_cnt + 1 + 2 * BW + 1;
        e.adds      = $countones(b);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // {load_ops, init_acc, load_acc, shift_en, done, busy} for BIT_WIDTH=2.
    logic [5:0] seq_exp [7] = '{6'b110001, 6'b001001, 6'b000101, 6'b001001,
                                6'b000101, 6'b000011, 6'b000000};

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   e0;
        exp_t e;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;

        // Asynchronous reset asserted mid-cycle, before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("rst_outs", 64'({bus.load_ops, bus.init_acc, bus.load_acc, bus.shift_en,
                               bus.done, bus.busy}), 64'd0);
        check("rst_iter", 64'(bus.iter_count), 64'd0);
        check("rst_outs_bw2", 64'({bus2.load_ops, bus2.init_acc, bus2.load_acc,
                                   bus2.shift_en, bus2.done, bus2.busy}), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 64'({bus.busy, bus.done, bus.load_ops}), 64'd0);

        // Single operations through the datapath model.
        start_op(16'h0003, 16'hA5C3);
        drain(60);
        start_op(16'h1234, 16'h00FF);
        drain(60);
        start_op(16'hFFFF, 16'hFFFF);
        drain(60);

        // Start held high: accepted every 35 cycles.
        @(negedge clk);
        a_op      = 16'h00AB;
        b_op      = 16'h0F0F;
        bus.start = 1'b1;
        e0        = edge_cnt + 1;
        for (int i = 0; i < 3; i++) begin
            e.prod      = 32'h00AB * 32'h0F0F;
            e.done_edge = e0 + 35 * i + 2 * BW + 1;
            e.adds      = 8;
            sb.push_back(e);
        end
        while (edge_cnt < e0 + 70) @(negedge clk);
        bus.start = 1'b0;
        drain(150);

        // Abort in the 5th SHIFT cycle.
        @(negedge clk);
        a_op      = 16'h5555;
        b_op      = 16'hFFFF;
        bus.start = 1'b1;
        e0        = edge_cnt + 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (edge_cnt < e0 + 10) @(negedge clk);
        check("abort_cycle_shift", 64'(bus.shift_en), 64'd1);
        check("abort_cycle_iter", 64'(bus.iter_count), 64'd4);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 64'({bus.busy, bus.done}), 64'd0);
        check("abort_iter", 64'(bus.iter_count), 64'd4);
        repeat (40) @(negedge clk);

        // Abort together with start in IDLE: stays idle.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_start_idle", 64'(bus.busy), 64'd0);
        check("iter_hold_idle", 64'(bus.iter_count), 64'd4);

        start_op(16'h0101, 16'h8001);
        drain(60);

        // Asynchronous reset mid-operation.
        start_op(16'hFFFF, 16'hFFFF);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midop_rst_outs", 64'({bus.load_ops, bus.init_acc, bus.load_acc, bus.shift_en,
                                     bus.done, bus.busy}), 64'd0);
        check("midop_rst_iter", 64'(bus.iter_count), 64'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // BIT_WIDTH=2 trace with mplr_bit tied high.
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("bw2_seq%0d", i), 64'({bus2.load_ops, bus2.init_acc, bus2.load_acc,
                                                   bus2.shift_en, bus2.done, bus2.busy}),
                  64'(seq_exp[i]));
            if (i == 5) check("bw2_iter_done", 64'(bus2.iter_count), 64'd2);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
